// File: rtl/m_mult_pkg.sv
// Shared definitions for the sequential multiply unit.
//   mult_state_e : FSM state encoding (IDLE / CALC / DONE)
//   cnt_width()  : step-counter width for an N-bit operand
package m_mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } mult_state_e;

    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/m_cond_neg.sv
// Conditional two's-complement negation.
// Ports:
//   neg_i : 1 = negate, 0 = pass through
//   in_i  : W-bit input value
//   out_o : neg_i ? -in_i : in_i (modulo 2^W)
module m_cond_neg #(
    parameter int unsigned W = 32
) (
    input  logic         neg_i,
    input  logic [W-1:0] in_i,
    output logic [W-1:0] out_o
);

    always_comb begin
        out_o = neg_i ? (~in_i + W'(1)) : in_i;
    end

endmodule

// File: rtl/m_seq_mult.sv
// Iterative N x N shift-add multiplier (MULT / MULTU) with valid/ready
// handshakes on both sides and a synchronous flush.
// Ports:
//   clk, rst             : clock, asynchronous active-high reset
//   in_valid / in_ready  : operand handshake (in_ready only in IDLE)
//   a, b, is_signed      : operands and mode, sampled on the accept edge
//   flush                : cancels in-flight work or a held result
//   out_valid / out_ready: result handshake (out_valid only in DONE)
//   hi, lo               : upper / lower halves of the 2N-bit product
module m_seq_mult
    import m_mult_pkg::*;
#(
    parameter int unsigned N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         is_signed,
    input  logic         flush,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] hi,
    output logic [N-1:0] lo
);

    localparam int unsigned      CNT_W    = cnt_width(N);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

    mult_state_e      state_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [N-1:0]     ma_q;
    logic [N-1:0]     acc_hi_q;
    // Multiplier and low accumulator share one register: each step consumes
    // bit 0 of the multiplier and the retired product bit enters at the top.
    logic [N-1:0]     mlo_q;
    logic             neg_q;
    logic [CNT_W-1:0] cnt_q;
    logic [N-1:0]     hi_q;
    logic [N-1:0]     lo_q;

    logic             a_neg_d;
    logic             b_neg_d;
    logic [N-1:0]     a_mag_d;
    logic [N-1:0]     b_mag_d;
    logic [N:0]       sum_d;
    logic [2*N-1:0]   raw_prod_d;
    logic [2*N-1:0]   prod_d;

    always_comb begin
        a_neg_d = is_signed & a[N-1];
        b_neg_d = is_signed & b[N-1];
    end

    // |-2^(N-1)| = 2^(N-1) still fits as an unsigned N-bit magnitude.
    m_cond_neg #(.W(N)) u_mag_a (
        .neg_i (a_neg_d),
        .in_i  (a),
        .out_o (a_mag_d)
    );

    m_cond_neg #(.W(N)) u_mag_b (
        .neg_i (b_neg_d),
        .in_i  (b),
        .out_o (b_mag_d)
    );

    // N+1-bit partial sum keeps the carry; the whole product as it would look
    // after this step's right shift is formed here so the final step can
    // register it directly.
    always_comb begin
        sum_d      = {1'b0, acc_hi_q} + (mlo_q[0] ? {1'b0, ma_q} : '0);
        raw_prod_d = {sum_d, mlo_q[N-1:1]};
    end

    m_cond_neg #(.W(2*N)) u_sign_fix (
        .neg_i (neg_q),
        .in_i  (raw_prod_d),
        .out_o (prod_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            ma_q        <= '0;
            acc_hi_q    <= '0;
            mlo_q       <= '0;
            neg_q       <= 1'b0;
            cnt_q       <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
        end else if (flush) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        ma_q       <= a_mag_d;
                        mlo_q      <= b_mag_d;
                        neg_q      <= a_neg_d ^ b_neg_d;
                        acc_hi_q   <= '0;
                        cnt_q      <= '0;
                        state_q    <= CALC;
                        in_ready_q <= 1'b0;
                    end
                end
                CALC: begin
                    acc_hi_q <= sum_d[N:1];
                    mlo_q    <= raw_prod_d[N-1:0];
                    cnt_q    <= cnt_q + 1'b1;
                    if (cnt_q == LAST_CNT) begin
                        hi_q        <= prod_d[2*N-1:N];
                        lo_q        <= prod_d[N-1:0];
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        in_ready  = in_ready_q;
        out_valid = out_valid_q;
        hi        = hi_q;
        lo        = lo_q;
    end

endmodule
